// File: rtl/control_pkg.sv
// ============================================================================
// control_pkg : opcodes, ALU ctrl codes, state encoding and strobe bundle
// Rev 1.0     : optional MULDIV_EN enables the mul/div sequences
// ============================================================================
`default_nettype none

package control_pkg;

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ROR  = 5'b00111;
    localparam logic [4:0] c_OP_ROL  = 5'b01000;
    localparam logic [4:0] c_OP_SHR  = 5'b01001;
    localparam logic [4:0] c_OP_SHRA = 5'b01010;
    localparam logic [4:0] c_OP_SHL  = 5'b01011;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_ANDI = 5'b01101;
    localparam logic [4:0] c_OP_ORI  = 5'b01110;
    localparam logic [4:0] c_OP_MUL  = 5'b01111;
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_NEG  = 5'b10001;
    localparam logic [4:0] c_OP_NOT  = 5'b10010;
    localparam logic [4:0] c_OP_BR   = 5'b10011;
    localparam logic [4:0] c_OP_JR   = 5'b10100;
    localparam logic [4:0] c_OP_JAL  = 5'b10101;
    localparam logic [4:0] c_OP_IN   = 5'b10110;
    localparam logic [4:0] c_OP_OUT  = 5'b10111;
    localparam logic [4:0] c_OP_MFHI = 5'b11000;
    localparam logic [4:0] c_OP_MFLO = 5'b11001;
    localparam logic [4:0] c_OP_NOP  = 5'b11010;
    localparam logic [4:0] c_OP_HALT = 5'b11011;

    localparam logic [3:0] c_ALU_NONE = 4'd0;
    localparam logic [3:0] c_ALU_ADD  = 4'd2;
    localparam logic [3:0] c_ALU_SUB  = 4'd3;
    localparam logic [3:0] c_ALU_AND  = 4'd4;
    localparam logic [3:0] c_ALU_OR   = 4'd5;
    localparam logic [3:0] c_ALU_SHR  = 4'd6;
    localparam logic [3:0] c_ALU_SHRA = 4'd7;
    localparam logic [3:0] c_ALU_SHL  = 4'd8;
    localparam logic [3:0] c_ALU_ROR  = 4'd9;
    localparam logic [3:0] c_ALU_ROL  = 4'd10;
    localparam logic [3:0] c_ALU_MUL  = 4'd11;
    localparam logic [3:0] c_ALU_DIV  = 4'd12;
    localparam logic [3:0] c_ALU_NEG  = 4'd13;
    localparam logic [3:0] c_ALU_NOT  = 4'd14;

    // Tn is encoded as n+1 so the execute step number is state-1.
    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic wren;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic zlow_out;
        logic zhigh_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic con_input;
        logic inport_out;
        logic outport_en;
        logic lo_in;
        logic lo_out;
        logic hi_in;
        logic hi_out;
    } strobes_t;

    // Final execute step (3..7) of an opcode; 0 means the fetch alone completes it.
    function automatic logic [2:0] last_step(input logic [4:0] op);
        case (op)
            c_OP_LD, c_OP_ST:                                   last_step = 3'd7;
            c_OP_BR:                                            last_step = 3'd6;
            c_OP_LDI, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_ROR, c_OP_ROL, c_OP_SHR, c_OP_SHRA, c_OP_SHL,
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI:                     last_step = 3'd5;
            c_OP_NEG, c_OP_NOT, c_OP_JAL:                       last_step = 3'd4;
            c_OP_JR, c_OP_IN, c_OP_OUT, c_OP_MFHI, c_OP_MFLO:   last_step = 3'd3;
`ifdef MULDIV_EN
            c_OP_MUL, c_OP_DIV:                                 last_step = 3'd6;
`endif
            default:                                            last_step = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            c_OP_SUB:              alu_code = c_ALU_SUB;
            c_OP_AND, c_OP_ANDI:   alu_code = c_ALU_AND;
            c_OP_OR,  c_OP_ORI:    alu_code = c_ALU_OR;
            c_OP_SHR:              alu_code = c_ALU_SHR;
            c_OP_SHRA:             alu_code = c_ALU_SHRA;
            c_OP_SHL:              alu_code = c_ALU_SHL;
            c_OP_ROR:              alu_code = c_ALU_ROR;
            c_OP_ROL:              alu_code = c_ALU_ROL;
            c_OP_MUL:              alu_code = c_ALU_MUL;
            c_OP_DIV:              alu_code = c_ALU_DIV;
            c_OP_NEG:              alu_code = c_ALU_NEG;
            c_OP_NOT:              alu_code = c_ALU_NOT;
            default:               alu_code = c_ALU_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
// control_decode : combinational state + opcode -> strobe and ALU ctrl decode
// Rev 1.0        : mul/div sequences present only with MULDIV_EN
// ============================================================================
`default_nettype none

module control_decode
    import control_pkg::*;
(
    input  state_t       i_state,
    input  logic [4:0]   i_opcode,
    input  logic         i_con,
    input  logic         i_stop,
    output strobes_t     o_strb,
    output logic [3:0]   o_ctrl
);

    always_comb begin
        o_strb = '0;
        o_ctrl = c_ALU_NONE;
        case (i_state)
            ST_T0: begin
                if (!i_stop) begin
                    o_strb.pc_out  = 1'b1;
                    o_strb.mar_in  = 1'b1;
                    o_strb.inc_pc  = 1'b1;
                    o_strb.zlow_in = 1'b1;
                end
            end
            ST_T1: begin
                o_strb.read     = 1'b1;
                o_strb.mdr_in   = 1'b1;
                o_strb.zlow_out = 1'b1;
                o_strb.pc_in    = 1'b1;
            end
            ST_T2: begin
                o_strb.mdr_out = 1'b1;
                o_strb.ir_in   = 1'b1;
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                case (i_opcode)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ROR, c_OP_ROL,
                    c_OP_SHR, c_OP_SHRA, c_OP_SHL, c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
                        if (i_state == ST_T3) begin
                            o_strb.grb   = 1'b1;
                            o_strb.r_out = 1'b1;
                            o_strb.y_in  = 1'b1;
                        end else if (i_state == ST_T4) begin
                            if (i_opcode inside {c_OP_ADDI, c_OP_ANDI, c_OP_ORI}) begin
                                o_strb.c_out = 1'b1;
                            end else begin
                                o_strb.grc   = 1'b1;
                                o_strb.r_out = 1'b1;
                            end
                            o_strb.zlow_in = 1'b1;
                            o_ctrl         = alu_code(i_opcode);
                        end else if (i_state == ST_T5) begin
                            o_strb.zlow_out = 1'b1;
                            o_strb.gra      = 1'b1;
                            o_strb.r_in     = 1'b1;
                        end
                    end
                    c_OP_NEG, c_OP_NOT: begin
                        if (i_state == ST_T3) begin
                            o_strb.grb     = 1'b1;
                            o_strb.r_out   = 1'b1;
                            o_strb.zlow_in = 1'b1;
                            o_ctrl         = alu_code(i_opcode);
                        end else if (i_state == ST_T4) begin
                            o_strb.zlow_out = 1'b1;
                            o_strb.gra      = 1'b1;
                            o_strb.r_in     = 1'b1;
                        end
                    end
                    // ld/ldi/st share the effective-address computation in T3-T5
                    c_OP_LD, c_OP_LDI, c_OP_ST: begin
                        if (i_state == ST_T3) begin
                            o_strb.grb    = 1'b1;
                            o_strb.ba_out = 1'b1;
                            o_strb.y_in   = 1'b1;
                        end else if (i_state == ST_T4) begin
                            o_strb.c_out   = 1'b1;
                            o_strb.zlow_in = 1'b1;
                            o_ctrl         = c_ALU_ADD;
                        end else if (i_state == ST_T5) begin
                            o_strb.zlow_out = 1'b1;
                            if (i_opcode == c_OP_LDI) begin
                                o_strb.gra  = 1'b1;
                                o_strb.r_in = 1'b1;
                            end else begin
                                o_strb.mar_in = 1'b1;
                            end
                        end else if (i_state == ST_T6) begin
                            o_strb.mdr_in = 1'b1;
                            if (i_opcode == c_OP_ST) begin
                                o_strb.gra   = 1'b1;
                                o_strb.r_out = 1'b1;
                            end else begin
                                o_strb.read  = 1'b1;
                            end
                        end else if (i_opcode == c_OP_ST) begin
                            o_strb.wren = 1'b1;
                        end else begin
                            o_strb.mdr_out = 1'b1;
                            o_strb.gra     = 1'b1;
                            o_strb.r_in    = 1'b1;
                        end
                    end
                    c_OP_BR: begin
                        if (i_state == ST_T3) begin
                            o_strb.gra       = 1'b1;
                            o_strb.r_out     = 1'b1;
                            o_strb.con_input = 1'b1;
                        end else if (i_state == ST_T4) begin
                            o_strb.pc_out = 1'b1;
                            o_strb.y_in   = 1'b1;
                        end else if (i_state == ST_T5) begin
                            o_strb.c_out   = 1'b1;
                            o_strb.zlow_in = 1'b1;
                            o_ctrl         = c_ALU_ADD;
                        end else if (i_state == ST_T6) begin
                            o_strb.zlow_out = 1'b1;
                            o_strb.pc_in    = i_con;
                        end
                    end
                    c_OP_JR: begin
                        o_strb.gra   = 1'b1;
                        o_strb.r_out = 1'b1;
                        o_strb.pc_in = 1'b1;
                    end
                    c_OP_JAL: begin
                        if (i_state == ST_T3) begin
                            o_strb.pc_out = 1'b1;
                            o_strb.grb    = 1'b1;
                            o_strb.r_in   = 1'b1;
                        end else begin
                            o_strb.gra   = 1'b1;
                            o_strb.r_out = 1'b1;
                            o_strb.pc_in = 1'b1;
                        end
                    end
                    c_OP_MFHI, c_OP_MFLO, c_OP_IN: begin
                        o_strb.hi_out     = (i_opcode == c_OP_MFHI);
                        o_strb.lo_out     = (i_opcode == c_OP_MFLO);
                        o_strb.inport_out = (i_opcode == c_OP_IN);
                        o_strb.gra        = 1'b1;
                        o_strb.r_in       = 1'b1;
                    end
                    c_OP_OUT: begin
                        o_strb.gra        = 1'b1;
                        o_strb.r_out      = 1'b1;
                        o_strb.outport_en = 1'b1;
                    end
`ifdef MULDIV_EN
                    c_OP_MUL, c_OP_DIV: begin
                        if (i_state == ST_T3) begin
                            o_strb.gra   = 1'b1;
                            o_strb.r_out = 1'b1;
                            o_strb.y_in  = 1'b1;
                        end else if (i_state == ST_T4) begin
                            o_strb.grb      = 1'b1;
                            o_strb.r_out    = 1'b1;
                            o_strb.zlow_in  = 1'b1;
                            o_strb.zhigh_in = 1'b1;
                            o_ctrl          = alu_code(i_opcode);
                        end else if (i_state == ST_T5) begin
                            o_strb.zlow_out = 1'b1;
                            o_strb.lo_in    = 1'b1;
                        end else if (i_state == ST_T6) begin
                            o_strb.zhigh_out = 1'b1;
                            o_strb.hi_in     = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : hardwired T-state sequencer; define MULDIV_EN for mul/div
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module control_unit
    import control_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        conOut,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        wren,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        conInput,
    output logic        InPortout,
    output logic        outPortEnable,
    output logic        LOin,
    output logic        LOout,
    output logic        HIin,
    output logic        HIout,
    output logic [3:0]  ctrl
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_opcode;
    logic [2:0] w_last;
    logic [3:0] w_step;
    strobes_t   w_strb;
    logic       w_unused_ir;

    assign w_opcode    = IR[31:27];
    assign w_unused_ir = ^IR[26:0];
    assign w_last      = last_step(w_opcode);
    assign w_step      = r_state - 4'd1;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET: w_next = ST_T0;
            ST_T0:    w_next = Stop ? ST_T0 : ST_T1;
            ST_T1:    w_next = ST_T2;
            ST_T2: begin
                if (w_opcode == c_OP_HALT) begin
                    w_next = ST_HALT;
                end else if (w_last == 3'd0) begin
                    w_next = ST_T0;
                end else begin
                    w_next = ST_T3;
                end
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                // Returning straight to T0 after the final step leaves no idle cycle.
                if (w_step == {1'b0, w_last}) begin
                    w_next = ST_T0;
                end else begin
                    w_next = state_t'(r_state + 4'd1);
                end
            end
            ST_HALT:  w_next = ST_HALT;
            default:  w_next = ST_RESET;
        endcase
    end

    control_decode u_decode (
        .i_state  (r_state),
        .i_opcode (w_opcode),
        .i_con    (conOut),
        .i_stop   (Stop),
        .o_strb   (w_strb),
        .o_ctrl   (ctrl)
    );

    assign Run           = (r_state != ST_RESET) && (r_state != ST_HALT);
    assign PCout         = w_strb.pc_out;
    assign PCin          = w_strb.pc_in;
    assign IncPC         = w_strb.inc_pc;
    assign MARin         = w_strb.mar_in;
    assign MDRin         = w_strb.mdr_in;
    assign MDRout        = w_strb.mdr_out;
    assign Read          = w_strb.read;
    assign wren          = w_strb.wren;
    assign IRin          = w_strb.ir_in;
    assign Yin           = w_strb.y_in;
    assign Zlowin        = w_strb.zlow_in;
    assign Zlowout       = w_strb.zlow_out;
    assign Gra           = w_strb.gra;
    assign Grb           = w_strb.grb;
    assign Grc           = w_strb.grc;
    assign Rin           = w_strb.r_in;
    assign Rout          = w_strb.r_out;
    assign BAout         = w_strb.ba_out;
    assign Cout          = w_strb.c_out;
    assign conInput      = w_strb.con_input;
    assign InPortout     = w_strb.inport_out;
    assign outPortEnable = w_strb.outport_en;
    assign LOout         = w_strb.lo_out;
    assign HIout         = w_strb.hi_out;

`ifdef MULDIV_EN
    assign Zhighin  = w_strb.zhigh_in;
    assign Zhighout = w_strb.zhigh_out;
    assign LOin     = w_strb.lo_in;
    assign HIin     = w_strb.hi_in;
`else
    logic w_unused_md;
    assign w_unused_md = ^{w_strb.zhigh_in, w_strb.zhigh_out, w_strb.lo_in, w_strb.hi_in};
    assign Zhighin  = 1'b0;
    assign Zhighout = 1'b0;
    assign LOin     = 1'b0;
    assign HIin     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : directed stepping of control_unit with per-cycle strobe checks
// Rev 1.0         : mul expectations follow MULDIV_EN
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        Clock, Clear, conOut, Stop;
    logic [31:0] IR;
    logic        Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, wren, IRin;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout;
    logic        BAout, Cout, conInput, InPortout, outPortEnable;
    logic        LOin, LOout, HIin, HIout;
    logic [3:0]  ctrl;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [27:0] NONE = 28'h0;
    localparam logic [27:0] S_PCOUT = 28'h1 << 0,  S_PCIN  = 28'h1 << 1,  S_INCPC = 28'h1 << 2;
    localparam logic [27:0] S_MARIN = 28'h1 << 3,  S_MDRIN = 28'h1 << 4,  S_MDROUT = 28'h1 << 5;
    localparam logic [27:0] S_READ  = 28'h1 << 6,  S_WREN  = 28'h1 << 7,  S_IRIN  = 28'h1 << 8;
    localparam logic [27:0] S_YIN   = 28'h1 << 9,  S_ZLIN  = 28'h1 << 10, S_ZHIN  = 28'h1 << 11;
    localparam logic [27:0] S_ZLOUT = 28'h1 << 12, S_ZHOUT = 28'h1 << 13, S_GRA   = 28'h1 << 14;
    localparam logic [27:0] S_GRB   = 28'h1 << 15, S_GRC   = 28'h1 << 16, S_RIN   = 28'h1 << 17;
    localparam logic [27:0] S_ROUT  = 28'h1 << 18, S_BAOUT = 28'h1 << 19, S_COUT  = 28'h1 << 20;
    localparam logic [27:0] S_CONIN = 28'h1 << 21, S_INP   = 28'h1 << 22, S_OUTP  = 28'h1 << 23;
    localparam logic [27:0] S_LOIN  = 28'h1 << 24, S_LOOUT = 28'h1 << 25, S_HIIN  = 28'h1 << 26;
    localparam logic [27:0] S_HIOUT = 28'h1 << 27;

    localparam logic [27:0] F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZLIN;
    localparam logic [27:0] F_T1 = S_READ | S_MDRIN | S_ZLOUT | S_PCIN;
    localparam logic [27:0] F_T2 = S_MDROUT | S_IRIN;

    localparam logic [3:0] K_ADD = 4'd2, K_MUL = 4'd11, K_NEG = 4'd13;

    logic [32:0] obs;
    assign obs = {ctrl, Run, HIout, HIin, LOout, LOin, outPortEnable, InPortout, conInput, Cout,
                  BAout, Rout, Rin, Grc, Grb, Gra, Zhighout, Zlowout, Zhighin, Zlowin, Yin,
                  IRin, wren, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .conOut(conOut), .Stop(Stop), .Run(Run),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .wren(wren), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .conInput(conInput), .InPortout(InPortout),
        .outPortEnable(outPortEnable), .LOin(LOin), .LOout(LOout), .HIin(HIin),
        .HIout(HIout), .ctrl(ctrl)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] instr(input logic [4:0] op);
        instr = {op, 27'h0};
    endfunction

    task automatic check(input string tag, input logic [27:0] s, input logic run, input logic [3:0] c);
        logic [32:0] exp;
        exp = {c, run, s};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [27:0] s, input logic run, input logic [3:0] c);
        @(posedge Clock);
        #1;
        check(tag, s, run, c);
    endtask

    // Enter T0, load the next instruction word, then run T1 and T2.
    task automatic fetch(input string tag, input logic [31:0] ir);
        step({tag, "_T0"}, F_T0, 1'b1, 4'd0);
        IR = ir;
        step({tag, "_T1"}, F_T1, 1'b1, 4'd0);
        step({tag, "_T2"}, F_T2, 1'b1, 4'd0);
    endtask

    initial begin
        Clear = 1'b1; Stop = 1'b0; conOut = 1'b0; IR = instr(5'b00011);
        #1 Clear = 1'b0;
        #1 check("reset_async", NONE, 1'b0, 4'd0);
        @(posedge Clock); #1 check("reset_hold", NONE, 1'b0, 4'd0);
        @(negedge Clock) Clear = 1'b1;

        // add
        fetch("add", instr(5'b00011));
        step("add_T3", S_GRB | S_ROUT | S_YIN, 1'b1, 4'd0);
        step("add_T4", S_GRC | S_ROUT | S_ZLIN, 1'b1, K_ADD);
        Stop = 1'b1;
        step("add_T5_stop_ignored", S_ZLOUT | S_GRA | S_RIN, 1'b1, 4'd0);

        // Stop holds T0 with no strobes
        step("stop_T0_a", NONE, 1'b1, 4'd0);
        step("stop_T0_b", NONE, 1'b1, 4'd0);
        Stop = 1'b0;
        #1 check("stop_release_T0", F_T0, 1'b1, 4'd0);
        IR = instr(5'b10011);
        step("br0_T1", F_T1, 1'b1, 4'd0);
        step("br0_T2", F_T2, 1'b1, 4'd0);
        step("br0_T3", S_GRA | S_ROUT | S_CONIN, 1'b1, 4'd0);
        step("br0_T4", S_PCOUT | S_YIN, 1'b1, 4'd0);
        step("br0_T5", S_COUT | S_ZLIN, 1'b1, K_ADD);
        step("br0_T6", S_ZLOUT, 1'b1, 4'd0);

        // br taken
        conOut = 1'b1;
        fetch("br1", instr(5'b10011));
        step("br1_T3", S_GRA | S_ROUT | S_CONIN, 1'b1, 4'd0);
        step("br1_T4", S_PCOUT | S_YIN, 1'b1, 4'd0);
        step("br1_T5", S_COUT | S_ZLIN, 1'b1, K_ADD);
        step("br1_T6", S_ZLOUT | S_PCIN, 1'b1, 4'd0);
        conOut = 1'b0;

        // ld then st back-to-back
        fetch("ld", instr(5'b00000));
        step("ld_T3", S_GRB | S_BAOUT | S_YIN, 1'b1, 4'd0);
        step("ld_T4", S_COUT | S_ZLIN, 1'b1, K_ADD);
        step("ld_T5", S_ZLOUT | S_MARIN, 1'b1, 4'd0);
        step("ld_T6", S_READ | S_MDRIN, 1'b1, 4'd0);
        step("ld_T7", S_MDROUT | S_GRA | S_RIN, 1'b1, 4'd0);
        fetch("st", instr(5'b00010));
        step("st_T3", S_GRB | S_BAOUT | S_YIN, 1'b1, 4'd0);
        step("st_T4", S_COUT | S_ZLIN, 1'b1, K_ADD);
        step("st_T5", S_ZLOUT | S_MARIN, 1'b1, 4'd0);
        step("st_T6", S_GRA | S_ROUT | S_MDRIN, 1'b1, 4'd0);
        step("st_T7", S_WREN, 1'b1, 4'd0);

        fetch("neg", instr(5'b10001));
        step("neg_T3", S_GRB | S_ROUT | S_ZLIN, 1'b1, K_NEG);
        step("neg_T4", S_ZLOUT | S_GRA | S_RIN, 1'b1, 4'd0);

        fetch("addi", instr(5'b01100));
        step("addi_T3", S_GRB | S_ROUT | S_YIN, 1'b1, 4'd0);
        step("addi_T4", S_COUT | S_ZLIN, 1'b1, K_ADD);
        step("addi_T5", S_ZLOUT | S_GRA | S_RIN, 1'b1, 4'd0);

        fetch("jal", instr(5'b10101));
        step("jal_T3", S_PCOUT | S_GRB | S_RIN, 1'b1, 4'd0);
        step("jal_T4", S_GRA | S_ROUT | S_PCIN, 1'b1, 4'd0);

        fetch("nop", instr(5'b11010));
        fetch("undef", instr(5'b11111));

        fetch("mul", instr(5'b01111));
`ifdef MULDIV_EN
        step("mul_T3", S_GRA | S_ROUT | S_YIN, 1'b1, 4'd0);
        step("mul_T4", S_GRB | S_ROUT | S_ZLIN | S_ZHIN, 1'b1, K_MUL);
        step("mul_T5", S_ZLOUT | S_LOIN, 1'b1, 4'd0);
        step("mul_T6", S_ZHOUT | S_HIIN, 1'b1, 4'd0);
`endif

        // Clear during ld T4
        fetch("ldclr", instr(5'b00000));
        step("ldclr_T3", S_GRB | S_BAOUT | S_YIN, 1'b1, 4'd0);
        step("ldclr_T4", S_COUT | S_ZLIN, 1'b1, K_ADD);
        Clear = 1'b0;
        #1 check("ldclr_async", NONE, 1'b0, 4'd0);
        #2 Clear = 1'b1;

        // halt, then restart by Clear pulse
        fetch("halt", instr(5'b11011));
        step("halt_enter", NONE, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            step("halt_hold", NONE, 1'b0, 4'd0);
        end
        Clear = 1'b0;
        #2 Clear = 1'b1;
        step("halt_restart_T0", F_T0, 1'b1, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  system clock; all state changes occur on the rising edge.
REQ-002 Clear  in  1  asynchronous, active-low reset.
REQ-003 IR  in  32  instruction register contents from the datapath; opcode is IR[31:27].
REQ-004 conOut  in  1  CON flip-flop result from the datapath.
REQ-005 Stop  in  1  when high, the block SHALL hold at T0 and not begin a fetch.
REQ-006 Run  out  1  high whenever the block is neither in reset nor halted.
REQ-007 PCout, PCin, IncPC  out  1 each  drive PC to bus / load PC / increment PC.
REQ-008 MARin, MDRin, MDRout, Read, wren  out  1 each  memory-side strobes.
REQ-009 IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout  out  1 each  IR/Y/Z register strobes.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select field and register-file strobes.
REQ-011 Cout, conInput, InPortout, outPortEnable  out  1 each  constant, CON, and I/O strobes.
REQ-012 LOin, LOout, HIin, HIout  out  1 each  LO/HI register strobes.
REQ-013 ctrl  out  4  ALU operation select; ADD SHALL be 4'd2.

Function
REQ-014 States SHALL be RESET, T0..T7 and HALT; outputs SHALL be decoded from the registered state and IR, and SHALL be stable for the whole cycle.
REQ-015 Fetch: T0 PCout MARin IncPC Zlowin; T1 Read MDRin Zlowout PCin; T2 MDRout IRin.
REQ-016 R-type ALU ops (add, sub, and, or, shr, shra, shl, ror, rol): T3 Grb Rout Yin; T4 Grc Rout ctrl=op Zlowin; T5 Zlowout Gra Rin.
REQ-017 addi, andi, ori: same as REQ-016 except T4 SHALL assert Cout instead of Grc Rout.
REQ-018 neg, not: T3 Grb Rout ctrl=op Zlowin; T4 Zlowout Gra Rin.
REQ-019 ld: T3 Grb BAout Yin; T4 Cout ctrl=ADD Zlowin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
REQ-020 ldi: ld T3-T4 sequence, then T5 Zlowout Gra Rin.
REQ-021 st: ld T3-T5 sequence; T6 Gra Rout MDRin (Read=0); T7 wren.
REQ-022 br: T3 Gra Rout conInput; T4 PCout Yin; T5 Cout ctrl=ADD Zlowin; T6 Zlowout, with PCin asserted only if conOut=1.
REQ-023 jr: T3 Gra Rout PCin.
REQ-024 jal: T3 PCout Grb Rin; T4 Gra Rout PCin.
REQ-025 mfhi and mflo: T3 HIout (or LOout) Gra Rin.
REQ-026 in: T3 InPortout Gra Rin.
REQ-027 out: T3 Gra Rout outPortEnable.
REQ-028 nop, and any undefined opcode, SHALL go T2 -> T0.
REQ-029 halt SHALL go T2 -> HALT; HALT SHALL hold until Clear, with Run=0 and all strobes 0.
REQ-030 After the last step of each instruction the next state SHALL be T0, giving zero dead cycles between instructions.
REQ-031 With Stop=1 in T0, all strobes SHALL be 0 and the state SHALL remain T0; execution resumes the cycle after Stop falls.
REQ-032 Stop SHALL be ignored outside T0.
REQ-033 ctrl SHALL be 0 whenever no ALU strobe (Zlowin) is asserted.

Reset
REQ-034 Clear low SHALL force RESET immediately, including mid-instruction, with all outputs 0 and Run=0.
REQ-035 The first rising edge after Clear rises SHALL move RESET -> T0.

Configuration
REQ-036 With MULDIV_EN defined, mul and div SHALL execute: T3 Gra Rout Yin; T4 Grb Rout ctrl=op Zlowin Zhighin; T5 Zlowout LOin; T6 Zhighout HIin.
REQ-037 Without MULDIV_EN, mul and div SHALL behave as nop, and the LOin/HIin/Zhighin/Zhighout outputs SHALL be tied 0.

Structure
REQ-038 Package control_pkg SHALL hold the 5-bit opcode constants, the 4-bit ALU ctrl codes and the state enumeration.
REQ-039 One combinational sub-module, control_decode (state plus opcode to strobes), SHALL be used; the state register and next-state logic SHALL stay in control_unit.

Verification
REQ-040 Release Clear, Stop=0, IR=add (opcode 00011): required RESET,T0..T5,T0 with the exact strobes of REQ-015 and REQ-016, and ctrl=op only in T4.
REQ-041 br with conOut=0, then with conOut=1: PCin absent in T6, then PCin present in T6; in both cases the next state is T0.
REQ-042 ld then st back-to-back: 8 cycles each, Read in T1 and T6 for ld, wren only in T7 for st.
REQ-043 halt: Run falls in the cycle after T2, all strobes stay 0 for 20 cycles, and Clear pulse low restarts at T0.
REQ-044 Clear asserted during T4 of ld: outputs go 0 asynchronously, without waiting for an edge; the first edge after release enters T0 with no leftover strobes.
REQ-045 mul, built with and without MULDIV_EN: LOin in T5 and HIin in T6 when built with it; T2 -> T0 when built without it.
